core_stream_arbiter: RTL and testbench

CORE_STREAM_ARBITER -- requirements
Module: core_stream_arbiter

---
 rtl/rr_pick.sv | 52 +++++
 rtl/core_stream_arbiter.sv | 162 ++++++++++++++++
 tb/tb_core_stream_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin selector.
//
// Picks the first set bit of req_i strictly after position last_i, walking
// upward and wrapping past NUM_CORES-1 back to 0. last_i itself is checked
// last, so a lone requester that was served most recently can win again.
//
// Ports
//   req_i    in  NUM_CORES  request vector, one bit per core
//   last_i   in  IDW        index served most recently
//   idx_o    out IDW        winning index (0 when nothing requests)
//   found_o  out 1          high when at least one request is present
module rr_pick #(
  parameter int NUM_CORES = 4,
  parameter int IDW       = 2
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [IDW-1:0]       last_i,
  output logic [IDW-1:0]       idx_o,
  output logic                 found_o
);

  localparam int SHW = IDW + 1;
  localparam int SW  = IDW + 2;

  logic [SHW-1:0]       shamt_s;
  logic [NUM_CORES-1:0] rot_s;
  logic [SW-1:0]        off_s;
  logic [SW-1:0]        sum_s;

  // Rotate requests so bit 0 is the core right after last_i, find the lowest
  // set bit, then map the offset back to an absolute index modulo NUM_CORES.
  always_comb begin
    shamt_s = {1'b0, last_i} + SHW'(1);
    // Doubling the vector makes the rotation a plain shift; any shift up to
    // NUM_CORES still leaves NUM_CORES valid bits at the bottom.
    rot_s   = NUM_CORES'({req_i, req_i} >> shamt_s);
    found_o = |rot_s;
    off_s   = '0;
    // Descending scan: the last assignment made is the lowest set bit.
    for (int p = NUM_CORES - 1; p >= 0; p--) begin
      off_s = rot_s[p] ? SW'(p) : off_s;
    end
    // last + 1 + off never exceeds 2*NUM_CORES-1, so one subtraction wraps it.
    sum_s = {2'b00, last_i} + SW'(1) + off_s;
    if (sum_s >= SW'(NUM_CORES)) begin
      idx_o = IDW'(sum_s - SW'(NUM_CORES));
    end else begin
      idx_o = IDW'(sum_s);
    end
  end

endmodule

// File: rtl/core_stream_arbiter.sv
// core_stream_arbiter -- merges NUM_CORES AXI-Stream byte streams into one
// stream with packet atomicity. Grants are round-robin, one arbitration cycle
// between packets; once a core is granted it keeps the grant until its tlast
// beat transfers, even if its tvalid drops in between.
//
// Ports
//   i_clk     in  1            clock, rising edge
//   i_rst     in  1            synchronous active-high reset
//   i_tdata   in  8*NUM_CORES  per-core byte, core k in [8k+7:8k]
//   i_tlast   in  NUM_CORES    per-core end-of-packet
//   i_tvalid  in  NUM_CORES    per-core beat valid
//   o_tready  out NUM_CORES    per-core beat accept (only the granted core)
//   o_tdata   out 8            merged byte (registered)
//   o_tlast   out 1            merged end-of-packet (registered)
//   o_tvalid  out 1            merged beat valid (registered)
//   i_tready  in  1            downstream accept
//   o_tid     out IDW          core that sourced the current output beat
//   o_busy    out 1            high while a packet grant is held
module core_stream_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic                                                  i_clk,
  input  logic                                                  i_rst,
  input  logic [8*NUM_CORES-1:0]                                i_tdata,
  input  logic [NUM_CORES-1:0]                                  i_tlast,
  input  logic [NUM_CORES-1:0]                                  i_tvalid,
  output logic [NUM_CORES-1:0]                                  o_tready,
  output logic [7:0]                                            o_tdata,
  output logic                                                  o_tlast,
  output logic                                                  o_tvalid,
  input  logic                                                  i_tready,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0]  o_tid,
  output logic                                                  o_busy
);

  localparam int IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [0:0]     ST_IDLE  = 1'b0;
  localparam logic [0:0]     ST_LOCK  = 1'b1;
  // Reset to the top index so core 0 is the first one after it.
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_CORES - 1);

  logic [0:0]           state_q,  state_d;
  logic [IDW-1:0]       grant_q,  grant_d;
  logic [IDW-1:0]       last_g_q, last_g_d;
  logic [7:0]           tdata_q,  tdata_d;
  logic                 tlast_q,  tlast_d;
  logic [IDW-1:0]       tid_q,    tid_d;
  logic                 tvalid_q, tvalid_d;

  logic [IDW-1:0]       pick_idx_s;
  logic                 pick_found_s;
  logic                 sel_valid_s;
  logic                 sel_last_s;
  logic [7:0]           sel_data_s;
  logic                 out_free_s;
  logic                 xfer_s;
  logic [NUM_CORES-1:0] tready_s;

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .IDW       (IDW)
  ) u_rr_pick (
    .req_i   (i_tvalid),
    .last_i  (last_g_q),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

  // Select the granted core's valid/last/data.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 8'h00;
    for (int k = 0; k < NUM_CORES; k++) begin
      sel_valid_s = (IDW'(k) == grant_q) ? i_tvalid[k]         : sel_valid_s;
      sel_last_s  = (IDW'(k) == grant_q) ? i_tlast[k]          : sel_last_s;
      sel_data_s  = (IDW'(k) == grant_q) ? i_tdata[8*k +: 8]   : sel_data_s;
    end
  end

  // The output register can take a beat when empty or being drained now;
  // only the granted core sees ready, and only while locked.
  always_comb begin
    out_free_s = !tvalid_q || i_tready;
    tready_s   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      tready_s[k] = (state_q == ST_LOCK) && (IDW'(k) == grant_q) && out_free_s;
    end
    xfer_s = (state_q == ST_LOCK) && sel_valid_s && out_free_s;
  end

  // Next-state: arbitration in IDLE, beat transfer and packet end in LOCK.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_g_d = last_g_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tid_d    = tid_q;
    // A held beat leaves once downstream accepts it; a refill below overrides.
    tvalid_d = tvalid_q && !i_tready;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = ST_LOCK;
          grant_d = pick_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (xfer_s) begin
          tdata_d  = sel_data_s;
          tlast_d  = sel_last_s;
          tid_d    = grant_q;
          tvalid_d = 1'b1;
          if (sel_last_s) begin
            state_d  = ST_IDLE;
            last_g_d = grant_q;
          end else begin
            state_d = ST_LOCK;
          end
        end else begin
          state_d = ST_LOCK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any held beat and partial grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_g_q <= LAST_RST;
      tdata_q  <= 8'h00;
      tlast_q  <= 1'b0;
      tid_q    <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_g_q <= last_g_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tid_q    <= tid_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign o_tready = tready_s;
  assign o_tdata  = tdata_q;
  assign o_tlast  = tlast_q;
  assign o_tvalid = tvalid_q;
  assign o_tid    = tid_q;
  assign o_busy   = (state_q == ST_LOCK);

endmodule

// File: tb/tb_core_stream_arbiter.sv
// Scoreboard bench for core_stream_arbiter: a 4-core instance exercised with
// directed packet scenarios and random traffic, plus a 1-core instance.
module tb_core_stream_arbiter;

  localparam int N = 4;

  typedef struct {
    int         cyc;
    int         tid;
    logic       last;
    logic [7:0] data;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-core instance
  logic             rst;
  logic [8*N-1:0]   tdata;
  logic [N-1:0]     tlast;
  logic [N-1:0]     tvalid;
  logic [N-1:0]     tready_o;
  logic [7:0]       odata;
  logic             olast;
  logic             ovalid;
  logic             iready;
  logic [1:0]       otid;
  logic             obusy;

  core_stream_arbiter #(.NUM_CORES(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(tvalid),
    .o_tready(tready_o), .o_tdata(odata), .o_tlast(olast), .o_tvalid(ovalid),
    .i_tready(iready), .o_tid(otid), .o_busy(obusy)
  );

  // 1-core instance
  logic       rst1;
  logic [7:0] tdata1;
  logic [0:0] tlast1;
  logic [0:0] tvalid1;
  logic [0:0] tready1;
  logic [7:0] odata1;
  logic       olast1;
  logic       ovalid1;
  logic       iready1;
  logic [0:0] otid1;
  logic       obusy1;

  core_stream_arbiter #(.NUM_CORES(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_tdata(tdata1), .i_tlast(tlast1), .i_tvalid(tvalid1),
    .o_tready(tready1), .o_tdata(odata1), .o_tlast(olast1), .o_tvalid(ovalid1),
    .i_tready(iready1), .o_tid(otid1), .o_busy(obusy1)
  );

  // Source packets not yet accepted, and accepted beats awaiting output.
  logic [8:0] src_q [N][$];
  logic [8:0] exp_q [N][$];
  ent_t       log_q [$];
  logic [N-1:0] gate;
  int         acc_cnt [N];
  int         locked = -1;
  bit         stall_chk;

  logic [8:0] src1_q [$];
  logic [8:0] exp1_q [$];
  int         out1_cnt = 0;

  // monitor state
  bit         prev_hold;
  logic [10:0] prev_word;
  bit         in_pkt;
  int         cur_tid;
  logic [8:0] mon_b;
  logic [8:0] mon1_b;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += src_q[k].size() + exp_q[k].size();
    return s;
  endfunction

  task automatic add_pkt(input int k, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) src_q[k].push_back({(i == len - 1), 8'(base + 8'(i))});
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        tvalid[k]         = gate[k];
        tdata[8*k +: 8]   = src_q[k][0][7:0];
        tlast[k]          = src_q[k][0][8];
      end else begin
        tvalid[k]         = 1'b0;
        tdata[8*k +: 8]   = 8'h00;
        tlast[k]          = 1'b0;
      end
    end
  endtask

  // One cycle: drive, check input-side handshake rules, record accepted beats.
  task automatic step();
    logic [N-1:0] acc;
    logic [8:0]   b;
    drive();
    #2;
    acc = tvalid & tready_o;
    if (locked >= 0) check("tready_exclusive", 32'(tready_o & ~(4'(1) << locked)), 32'd0);
    else             check("tready_onehot", 32'($countones(tready_o) <= 1), 32'd1);
    if (stall_chk) begin
      check("stall_valid", 32'(ovalid), 32'd1);
      check("stall_tready", 32'(tready_o), 32'd0);
    end
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        b = src_q[k].pop_front();
        exp_q[k].push_back(b);
        acc_cnt[k]++;
        if (locked < 0) locked = k;
        if (b[8]) locked = -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; iready = 1'b1; stall_chk = 1'b0; gate = '1; locked = -1;
    for (int k = 0; k < N; k++) begin
      src_q[k].delete(); exp_q[k].delete(); acc_cnt[k] = 0;
    end
    log_q.delete();
    drive();
    repeat (2) @(negedge clk);
    #1;
    check("rst_tvalid", 32'(ovalid), 32'd0);
    check("rst_tlast",  32'(olast),  32'd0);
    check("rst_tdata",  32'(odata),  32'd0);
    check("rst_tid",    32'(otid),   32'd0);
    check("rst_tready", 32'(tready_o), 32'd0);
    check("rst_busy",   32'(obusy),  32'd0);
    rst = 1'b0;
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_complete", 32'(pending()), 32'd0);
  endtask

  // Output monitor: pops the expected beat for the reported core and checks
  // hold-while-stalled and packet atomicity on the merged stream.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_hold = 1'b0;
      in_pkt    = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid",  32'(ovalid), 32'd1);
        check("hold_stable", 32'({olast, otid, odata}), 32'(prev_word));
      end
      if (ovalid && iready) begin
        check("beat_expected", 32'(exp_q[otid].size() > 0), 32'd1);
        if (exp_q[otid].size() > 0) begin
          mon_b = exp_q[otid].pop_front();
          check("beat_data", 32'({olast, odata}), 32'(mon_b));
        end
        if (in_pkt) check("out_atomic", 32'(otid), 32'(cur_tid));
        in_pkt  = !olast;
        cur_tid = int'(otid);
        log_q.push_back('{cyc: cyc, tid: int'(otid), last: olast, data: odata});
      end
      prev_hold = ovalid && !iready;
      prev_word = {olast, otid, odata};
    end
  end

  // Monitor for the single-core instance.
  always begin
    @(negedge clk);
    #2;
    if (!rst1 && ovalid1 && iready1) begin
      check("n1_beat_expected", 32'(exp1_q.size() > 0), 32'd1);
      if (exp1_q.size() > 0) begin
        mon1_b = exp1_q.pop_front();
        check("n1_beat_data", 32'({olast1, odata1}), 32'(mon1_b));
      end
      check("n1_tid", 32'(otid1), 32'd0);
      out1_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:0] acc1;
    rst = 1'b1; iready = 1'b1; gate = '1; tvalid = '0; tdata = '0; tlast = '0; stall_chk = 1'b0;
    rst1 = 1'b1; iready1 = 1'b0; tvalid1 = '0; tdata1 = 8'h00; tlast1 = '0;
    @(negedge clk);

    // Two competing 3-byte packets: core 0 first, one idle cycle, then core 2.
    do_reset();
    add_pkt(0, 3, 8'hA0);
    add_pkt(2, 3, 8'hC0);
    run_until_empty(50);
    check("t2_count", 32'(log_q.size()), 32'd6);
    if (log_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("t2_tid",  32'(log_q[i].tid),  (i < 3) ? 32'd0 : 32'd2);
        check("t2_data", 32'(log_q[i].data), 32'(((i < 3) ? 8'hA0 : 8'hC0) + 8'(i % 3)));
        check("t2_last", 32'(log_q[i].last), 32'((i % 3) == 2));
        if (i > 0) check("t2_gap", 32'(log_q[i].cyc - log_q[i-1].cyc), (i == 3) ? 32'd2 : 32'd1);
      end
    end

    // All cores with back-to-back 1-byte packets: strict rotation, one per 2 cycles.
    do_reset();
    for (int k = 0; k < N; k++)
      for (int n = 0; n < 2; n++) add_pkt(k, 1, 8'(k * 16 + n));
    run_until_empty(100);
    check("t3_count", 32'(log_q.size()), 32'd8);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t3_tid",  32'(log_q[i].tid),  32'(i % 4));
        check("t3_data", 32'(log_q[i].data), 32'((i % 4) * 16 + i / 4));
        if (i > 0) check("t3_gap", 32'(log_q[i].cyc - log_q[i-1].cyc), 32'd2);
      end
    end

    // Downstream stall of 5 cycles mid-packet.
    do_reset();
    add_pkt(1, 6, 8'h40);
    for (int n = 0; n < 20 && log_q.size() < 2; n++) step();
    check("t4_started", 32'(log_q.size()), 32'd2);
    iready = 1'b0; stall_chk = 1'b1;
    repeat (5) step();
    stall_chk = 1'b0; iready = 1'b1;
    run_until_empty(50);
    check("t4_count", 32'(log_q.size()), 32'd6);
    if (log_q.size() == 6)
      for (int i = 0; i < 6; i++) check("t4_order", 32'(log_q[i].data), 32'(8'h40 + 8'(i)));

    // Core 1 pauses mid-packet while core 3 waits.
    do_reset();
    add_pkt(1, 5, 8'h50);
    add_pkt(3, 2, 8'h70);
    for (int n = 0; n < 20 && acc_cnt[1] < 2; n++) step();
    gate[1] = 1'b0;
    repeat (3) step();
    check("t5_busy_held", 32'(obusy), 32'd1);
    check("t5_core3_waits", 32'(acc_cnt[3]), 32'd0);
    gate[1] = 1'b1;
    run_until_empty(50);
    check("t5_count", 32'(log_q.size()), 32'd7);
    if (log_q.size() == 7)
      for (int i = 0; i < 7; i++) check("t5_tid", 32'(log_q[i].tid), (i < 5) ? 32'd1 : 32'd3);

    // Reset while core 2 is mid-packet, then core 0 must win first.
    do_reset();
    add_pkt(2, 8, 8'h80);
    for (int n = 0; n < 20 && acc_cnt[2] < 3; n++) step();
    check("t6_mid", 32'(acc_cnt[2]), 32'd3);
    do_reset();
    add_pkt(0, 2, 8'h00);
    add_pkt(2, 2, 8'h20);
    step();
    check("t6_no_ghost_valid", 32'(ovalid), 32'd0);
    check("t6_busy_after_arb", 32'(obusy), 32'd1);
    run_until_empty(50);
    check("t6_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) check("t6_first_tid", 32'(log_q[0].tid), 32'd0);

    // Random traffic with random source pauses and downstream stalls.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() < 4 && $urandom_range(3) == 0)
          add_pkt(k, int'($urandom_range(5, 1)), 8'($urandom));
        gate[k] = ($urandom_range(9) != 0);
      end
      iready = ($urandom_range(3) != 0);
      step();
    end
    gate = '1; iready = 1'b1;
    run_until_empty(500);

    // Single-core build: 16-byte packet with downstream ready toggling.
    repeat (2) @(negedge clk);
    #1;
    check("n1_rst_valid", 32'(ovalid1), 32'd0);
    check("n1_rst_busy",  32'(obusy1),  32'd0);
    rst1 = 1'b0;
    for (int i = 0; i < 16; i++) src1_q.push_back({(i == 15), 8'(8'h10 + 8'(i))});
    for (int n = 0; n < 200 && out1_cnt < 16; n++) begin
      if (src1_q.size() > 0) begin
        tvalid1 = 1'b1; tdata1 = src1_q[0][7:0]; tlast1 = src1_q[0][8];
      end else begin
        tvalid1 = 1'b0; tdata1 = 8'h00; tlast1 = 1'b0;
      end
      iready1 = n[0];
      #2;
      acc1 = tvalid1 & tready1;
      @(posedge clk);
      if (acc1[0]) exp1_q.push_back(src1_q.pop_front());
      @(negedge clk);
    end
    check("n1_count", 32'(out1_cnt), 32'd16);
    check("n1_drained", 32'(exp1_q.size() + src1_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
